// File: rtl/tour_pkg.sv
// Shared state encodings, error codes and Knight command constants for tour_cmd_player.
// Bench tasks also use these constants to build scripts.
package tour_pkg;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ISSUE     = 3'd1;
    localparam logic [2:0] SEND      = 3'd2;
    localparam logic [2:0] WAIT_SNT  = 3'd3;
    localparam logic [2:0] WAIT_RESP = 3'd4;
    localparam logic [2:0] NEXT      = 3'd5;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_NAK     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    localparam logic [15:0] CAL_GYRO = 16'h2000;
    localparam logic [3:0]  MOVE_OP  = 4'h4;
    localparam logic [7:0]  NORTH    = 8'h00;
    localparam logic [7:0]  WEST     = 8'h3F;
    localparam logic [7:0]  SOUTH    = 8'h7F;
    localparam logic [7:0]  EAST     = 8'hBF;

    function automatic logic [15:0] move_cmd(input logic [7:0] heading, input logic [3:0] squares);
        return {MOVE_OP, heading, squares};
    endfunction

endpackage

// File: rtl/tour_cmd_player_if.sv
// Command/response link between the player (master) and RemoteComm (slave).
// cmd/snd_cmd flow out; cmd_snt, resp_rdy and resp flow back.
interface tour_cmd_player_if;
    logic [15:0] cmd;
    logic        snd_cmd;
    logic        cmd_snt;
    logic        resp_rdy;
    logic [7:0]  resp;

    modport master (output cmd, snd_cmd, input cmd_snt, resp_rdy, resp);
    modport slave  (input cmd, snd_cmd, output cmd_snt, resp_rdy, resp);
endinterface

// File: rtl/tour_script_ram.sv
// DEPTH x 16 script store: one write port, one registered read port (read data held when rd_en low).
// Contents survive reset; only the read register is cleared.
module tour_script_ram #(
    parameter int DEPTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [15:0]   rd_data
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/tour_cmd_player.sv
// Plays a script of Knight commands into RemoteComm: snd_cmd 2 clk after start, 3 clk after each ack;
// waits on cmd_snt then resp. TOUR_RETRY_EN re-issues an entry once after a response timeout.
module tour_cmd_player
    import tour_pkg::*;
#(
    parameter int          DEPTH        = 32,
    parameter logic [23:0] RESP_TIMEOUT = 24'hFF_FFFF,
    parameter logic [7:0]  ACK_BYTE     = 8'hA5,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [15:0]          wr_data,
    input  logic [AW:0]          num_cmds,
    input  logic                 start,
    tour_cmd_player_if.master    rc,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [AW-1:0]        cmd_idx
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [2:0]    state;
    logic [AW-1:0] last_idx;
    logic [23:0]   tcnt;
    logic [AW:0]   n_clamp;
    logic          timeout_hit;
`ifdef TOUR_RETRY_EN
    logic          retried;
`endif

    assign n_clamp     = (num_cmds > DEPTH_W) ? DEPTH_W : num_cmds;
    // tcnt holds clocks already spent in WAIT_RESP; this edge is the next one
    assign timeout_hit = ({1'b0, tcnt} + 25'd1) >= {1'b0, RESP_TIMEOUT};
    assign busy        = (state != IDLE);
    assign rc.snd_cmd  = (state == SEND);

    tour_script_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en && (state == IDLE)),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (state == ISSUE),
        .rd_addr (cmd_idx),
        .rd_data (rc.cmd)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            cmd_idx  <= '0;
            last_idx <= '0;
            tcnt     <= '0;
`ifdef TOUR_RETRY_EN
            retried  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        err      <= 1'b0;
                        err_code <= ERR_NONE;
                        cmd_idx  <= '0;
`ifdef TOUR_RETRY_EN
                        retried  <= 1'b0;
`endif
                        if (n_clamp == '0) begin
                            done <= 1'b1;
                        end else begin
                            done     <= 1'b0;
                            last_idx <= AW'(n_clamp - 1'b1);
                            state    <= ISSUE;
                        end
                    end
                end
                ISSUE:    state <= SEND;
                SEND:     state <= WAIT_SNT;
                WAIT_SNT: begin
                    if (rc.cmd_snt) begin
                        tcnt  <= '0;
                        state <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (rc.resp_rdy) begin
                        if (rc.resp == ACK_BYTE) begin
`ifdef TOUR_RETRY_EN
                            retried <= 1'b0;
`endif
                            state <= NEXT;
                        end else begin
                            err      <= 1'b1;
                            err_code <= ERR_NAK;
                            state    <= IDLE;
                        end
                    end else if (timeout_hit) begin
`ifdef TOUR_RETRY_EN
                        if (!retried) begin
                            retried <= 1'b1;
                            state   <= ISSUE;
                        end else begin
                            err      <= 1'b1;
                            err_code <= ERR_TIMEOUT;
                            state    <= IDLE;
                        end
`else
                        err      <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                        state    <= IDLE;
`endif
                    end else if (tcnt != '1) begin
                        tcnt <= tcnt + 24'd1;
                    end
                end
                NEXT: begin
                    if (cmd_idx == last_idx) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cmd_idx <= cmd_idx + 1'b1;
                        state   <= ISSUE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tour_cmd_player.sv
// Bench for tour_cmd_player: expected commands are queued from a script model when playback starts
// and compared against cmd at each snd_cmd pulse; RESP_TIMEOUT is shortened to 100.
module tb_tour_cmd_player;
    import tour_pkg::*;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int TO    = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [15:0]   wr_data = '0;
    logic [AW:0]   num_cmds = '0;
    logic          start = 1'b0;
    logic          busy, done, err;
    logic [1:0]    err_code;
    logic [AW-1:0] cmd_idx;

    tour_cmd_player_if rc();

    tour_cmd_player #(
        .DEPTH(DEPTH), .RESP_TIMEOUT(24'd100), .ACK_BYTE(8'hA5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .num_cmds(num_cmds), .start(start), .rc(rc), .busy(busy), .done(done),
        .err(err), .err_code(err_code), .cmd_idx(cmd_idx)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          snd_cnt = 0;
    bit          idle_ok;
    logic [15:0] mdl [DEPTH];
    logic [15:0] exp_q [$];
    logic [15:0] obs_q [$];
    int          lat_q [$];

    always @(posedge clk) if (rc.snd_cmd === 1'b1) snd_cnt++;

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic clr_pulses;
        start = 1'b0; wr_en = 1'b0; rc.cmd_snt = 1'b0; rc.resp_rdy = 1'b0;
    endtask

    task automatic write_entry(input int a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_data = d;
        tick;
        wr_en = 1'b0;
        mdl[a] = d;
    endtask

    // Ticks until snd_cmd is seen; lat counts ticks from the moment of the call, -1 on expiry.
    task automatic wait_snd(output int lat);
        lat = -1;
        for (int k = 1; k <= 300; k++) begin
            tick; clr_pulses;
            if (rc.snd_cmd === 1'b1) begin lat = k; break; end
        end
    endtask

    task automatic wait_idle;
        idle_ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick; clr_pulses;
            if (busy === 1'b0) begin idle_ok = 1'b1; break; end
        end
    endtask

    // Starts playback and acts as RemoteComm for n_snd commands; entry nak_at gets 8'h5A.
    task automatic play(input logic [AW:0] n, input int n_snd, input int nak_at);
        int lat;
        lat_q.delete(); obs_q.delete();
        num_cmds = n; start = 1'b1;
        for (int i = 0; i < n_snd; i++) begin
            wait_snd(lat);
            lat_q.push_back(lat);
            obs_q.push_back(rc.cmd);
            if (lat < 0) break;
            repeat (1 + $urandom_range(0, 2)) begin tick; clr_pulses; end
            rc.cmd_snt = 1'b1;
            tick; clr_pulses;
            repeat ($urandom_range(0, 3)) tick;
            rc.resp_rdy = 1'b1;
            rc.resp = (i == nak_at) ? 8'h5A : 8'hA5;
        end
        wait_idle;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) tick;
        n_tests++;
        if ({busy, done, err, err_code, rc.snd_cmd, cmd_idx, rc.cmd} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b code=%0d snd=%b idx=%0d cmd=%h, want all 0",
                     busy, done, err, err_code, rc.snd_cmd, cmd_idx, rc.cmd);
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_two_cmds;
        logic [15:0] e;
        write_entry(0, CAL_GYRO);
        write_entry(1, move_cmd(WEST, 4'h1));
        exp_q.push_back(mdl[0]); exp_q.push_back(mdl[1]);
        play(6'd2, 2, -1);
        n_tests++;
        if (lat_q.size() != 2 || lat_q[0] != 2) begin
            n_fail++; $display("FAIL start_latency: got %0d, want 2", (lat_q.size() > 0) ? lat_q[0] : -1);
        end
        n_tests++;
        if (lat_q.size() != 2 || lat_q[1] != 3) begin
            n_fail++; $display("FAIL ack_gap: got %0d, want 3", (lat_q.size() > 1) ? lat_q[1] : -1);
        end
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            n_tests++;
            if (i >= obs_q.size() || obs_q[i] !== e) begin
                n_fail++; $display("FAIL two_cmd_word%0d: got %h, want %h", i, (i < obs_q.size()) ? obs_q[i] : 16'hxxxx, e);
            end
        end
        n_tests++;
        if (!idle_ok || done !== 1'b1 || err !== 1'b0 || cmd_idx !== 5'd1) begin
            n_fail++; $display("FAIL two_cmd_end: got idle=%b done=%b err=%b idx=%0d, want 1 1 0 1", idle_ok, done, err, cmd_idx);
        end
    endtask

    task automatic test_nak;
        int base;
        logic [15:0] e;
        write_entry(2, move_cmd(SOUTH, 4'h2));
        exp_q.push_back(mdl[0]); exp_q.push_back(mdl[1]);
        base = snd_cnt;
        play(6'd3, 2, 1);
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            n_tests++;
            if (i >= obs_q.size() || obs_q[i] !== e) begin
                n_fail++; $display("FAIL nak_word%0d: got %h, want %h", i, (i < obs_q.size()) ? obs_q[i] : 16'hxxxx, e);
            end
        end
        repeat (5) tick;
        n_tests++;
        if (busy !== 1'b0 || err !== 1'b1 || err_code !== ERR_NAK || done !== 1'b0 || cmd_idx !== 5'd1) begin
            n_fail++; $display("FAIL nak_status: got busy=%b err=%b code=%0d done=%b idx=%0d, want 0 1 1 0 1",
                               busy, err, err_code, done, cmd_idx);
        end
        n_tests++;
        if (snd_cnt - base != 2) begin
            n_fail++; $display("FAIL nak_pulses: got %0d, want 2", snd_cnt - base);
        end
    endtask

    task automatic test_timeout;
        int lat, k_ev, base;
        base = snd_cnt;
        num_cmds = 6'd1; start = 1'b1;
        wait_snd(lat);
        n_tests++;
        if (lat != 2 || rc.cmd !== mdl[0]) begin
            n_fail++; $display("FAIL to_first: got lat=%0d cmd=%h, want 2 %h", lat, rc.cmd, mdl[0]);
        end
        tick;
        rc.cmd_snt = 1'b1; tick; clr_pulses;
        k_ev = -1;
        for (int k = 1; k <= 400; k++) begin
            tick;
            if (err === 1'b1 || rc.snd_cmd === 1'b1) begin k_ev = k; break; end
        end
`ifdef TOUR_RETRY_EN
        n_tests++;
        if (k_ev != TO + 1 || rc.snd_cmd !== 1'b1 || err !== 1'b0 || rc.cmd !== mdl[0]) begin
            n_fail++; $display("FAIL retry_issue: got k=%0d snd=%b err=%b cmd=%h, want %0d 1 0 %h",
                               k_ev, rc.snd_cmd, err, rc.cmd, TO + 1, mdl[0]);
        end
        tick;
        rc.cmd_snt = 1'b1; tick; clr_pulses;
        k_ev = -1;
        for (int k = 1; k <= 400; k++) begin
            tick;
            if (err === 1'b1 || rc.snd_cmd === 1'b1) begin k_ev = k; break; end
        end
`endif
        n_tests++;
        if (k_ev != TO || err !== 1'b1 || err_code !== ERR_TIMEOUT) begin
            n_fail++; $display("FAIL timeout: got k=%0d err=%b code=%0d, want %0d 1 2", k_ev, err, err_code, TO);
        end
        repeat (4) tick;
        n_tests++;
`ifdef TOUR_RETRY_EN
        if (busy !== 1'b0 || done !== 1'b0 || snd_cnt - base != 2) begin
`else
        if (busy !== 1'b0 || done !== 1'b0 || snd_cnt - base != 1) begin
`endif
            n_fail++; $display("FAIL timeout_end: got busy=%b done=%b pulses=%0d", busy, done, snd_cnt - base);
        end
    endtask

    task automatic test_busy_ignore;
        int lat, base;
        write_entry(0, CAL_GYRO);
        write_entry(1, move_cmd(NORTH, 4'h3));
        base = snd_cnt;
        num_cmds = 6'd2; start = 1'b1;
        wait_snd(lat);
        tick;
        start = 1'b1; wr_en = 1'b1; wr_addr = 5'd1; wr_data = 16'hFFFF;
        rc.resp_rdy = 1'b1; rc.resp = 8'hA5;
        tick; clr_pulses;
        repeat (4) tick;
        n_tests++;
        if (busy !== 1'b1 || cmd_idx !== 5'd0 || snd_cnt - base != 1 || err !== 1'b0) begin
            n_fail++; $display("FAIL busy_stray: got busy=%b idx=%0d pulses=%0d err=%b, want 1 0 1 0",
                               busy, cmd_idx, snd_cnt - base, err);
        end
        rc.cmd_snt = 1'b1; rc.resp_rdy = 1'b1; rc.resp = 8'hA5;
        tick; clr_pulses;
        repeat (5) tick;
        n_tests++;
        if (busy !== 1'b1 || snd_cnt - base != 1 || cmd_idx !== 5'd0) begin
            n_fail++; $display("FAIL resp_with_snt: got busy=%b pulses=%0d idx=%0d, want 1 1 0", busy, snd_cnt - base, cmd_idx);
        end
        exp_q.push_back(mdl[1]);
        rc.resp_rdy = 1'b1; rc.resp = 8'hA5;
        wait_snd(lat);
        n_tests++;
        if (lat != 3 || rc.cmd !== exp_q.pop_front()) begin
            n_fail++; $display("FAIL script_kept: got lat=%0d cmd=%h, want 3 %h", lat, rc.cmd, mdl[1]);
        end
        tick;
        rc.cmd_snt = 1'b1; tick; clr_pulses;
        rc.resp_rdy = 1'b1; rc.resp = 8'hA5;
        wait_idle;
        n_tests++;
        if (!idle_ok || done !== 1'b1 || err !== 1'b0) begin
            n_fail++; $display("FAIL busy_end: got idle=%b done=%b err=%b, want 1 1 0", idle_ok, done, err);
        end
    endtask

    task automatic test_reset_mid;
        int lat, base;
        logic [15:0] e;
        base = snd_cnt;
        num_cmds = 6'd2; start = 1'b1;
        wait_snd(lat);
        tick;
        rc.cmd_snt = 1'b1; tick; clr_pulses;
        repeat (3) tick;
        rst_n = 1'b0; tick; rst_n = 1'b1;
        n_tests++;
        if ({busy, done, err, err_code, rc.snd_cmd, cmd_idx, rc.cmd} !== '0) begin
            n_fail++; $display("FAIL mid_reset: got busy=%b done=%b err=%b code=%0d snd=%b idx=%0d cmd=%h, want all 0",
                               busy, done, err, err_code, rc.snd_cmd, cmd_idx, rc.cmd);
        end
        rc.resp_rdy = 1'b1; rc.resp = 8'hA5;
        tick; clr_pulses;
        repeat (6) tick;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || snd_cnt - base != 1) begin
            n_fail++; $display("FAIL late_ack: got busy=%b done=%b pulses=%0d, want 0 0 1", busy, done, snd_cnt - base);
        end
        exp_q.push_back(mdl[0]); exp_q.push_back(mdl[1]);
        play(6'd2, 2, -1);
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            n_tests++;
            if (i >= obs_q.size() || obs_q[i] !== e) begin
                n_fail++; $display("FAIL replay_word%0d: got %h, want %h", i, (i < obs_q.size()) ? obs_q[i] : 16'hxxxx, e);
            end
        end
        n_tests++;
        if (!idle_ok || done !== 1'b1 || cmd_idx !== 5'd1) begin
            n_fail++; $display("FAIL replay_end: got idle=%b done=%b idx=%0d, want 1 1 1", idle_ok, done, cmd_idx);
        end
    endtask

    task automatic test_zero;
        int base;
        base = snd_cnt;
        num_cmds = 6'd0; start = 1'b1;
        tick; clr_pulses;
        repeat (5) tick;
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || snd_cnt != base) begin
            n_fail++; $display("FAIL zero_cmds: got done=%b busy=%b err=%b pulses=%0d, want 1 0 0 0",
                               done, busy, err, snd_cnt - base);
        end
    endtask

    task automatic test_full(input logic [AW:0] n);
        int base, bad;
        logic [15:0] e;
        logic [7:0] hd [4];
        hd[0] = NORTH; hd[1] = WEST; hd[2] = SOUTH; hd[3] = EAST;
        for (int i = 0; i < DEPTH; i++) write_entry(i, move_cmd(hd[i % 4], 4'(i % 16)));
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(mdl[i]);
        base = snd_cnt;
        play(n, DEPTH, -1);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            e = exp_q.pop_front();
            n_tests++;
            if (i >= obs_q.size() || obs_q[i] !== e) begin
                n_fail++; bad++;
                if (bad < 4) $display("FAIL full%0d_word%0d: got %h, want %h", n, i, (i < obs_q.size()) ? obs_q[i] : 16'hxxxx, e);
            end
        end
        repeat (4) tick;
        n_tests++;
        if (!idle_ok || done !== 1'b1 || err !== 1'b0 || cmd_idx !== 5'd31 || snd_cnt - base != DEPTH) begin
            n_fail++; $display("FAIL full%0d_end: got idle=%b done=%b err=%b idx=%0d pulses=%0d, want 1 1 0 31 32",
                               n, idle_ok, done, err, cmd_idx, snd_cnt - base);
        end
    endtask

    initial begin
        rc.cmd_snt = 1'b0; rc.resp_rdy = 1'b0; rc.resp = 8'h00;
        test_reset;
        test_two_cmds;
        test_nak;
        test_timeout;
        test_busy_ignore;
        test_reset_mid;
        test_zero;
        test_full(6'd32);
        test_full(6'd45);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d failed so far", n_fail);
        $fatal(1);
    end

endmodule
